// File: rtl/tlm_feeder_pkg.sv
// Shared types for the batch stream feeder: FSM state encoding and an
// operand extraction helper for packed NUM_CH x ITEM_WIDTH entries.
package tlm_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int MAX_DW   = 256;
  localparam int MAX_OP_W = 32;

  // Operand k of width w from a packed entry (operand k at bits [k*w +: w]).
  function automatic logic [MAX_OP_W-1:0] operand_slice(
    input logic [MAX_DW-1:0] word,
    input int unsigned       k,
    input int unsigned       w
  );
    logic [MAX_OP_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OP_W; i++) begin
      if ((i < w) && ((k * w + i) < MAX_DW)) r[i] = word[k * w + i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tlm_stream_feeder_if.sv
// Valid/ready stream bundle. A beat transfers on a rising clock edge where
// valid && ready; the master holds valid and data stable until that edge.
interface tlm_stream_feeder_if #(
  parameter int DW = 16
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tlm_feeder_buf.sv
// Batch storage: DEPTH x DW register array, synchronous write, combinational read.
module tlm_feeder_buf #(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/tlm_stream_feeder.sv
// Fills a batch buffer through a valid/ready write port, then streams it to a
// downstream BFM with zero-bubble throughput, optionally looping the batch.
module tlm_stream_feeder
  import tlm_feeder_pkg::*;
#(
  parameter  int NUM_ITEMS  = 100,
  parameter  int NUM_CH     = 2,
  parameter  int ITEM_WIDTH = 8,
  localparam int CNT_W      = $clog2(NUM_ITEMS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  tlm_stream_feeder_if.slave  wr,
  tlm_stream_feeder_if.master m,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic               loop_i,
  output logic               batch_done_o,
  output logic               xmit_en_o,
  output logic [CNT_W-1:0]   fill_cnt_o,
  output logic [CNT_W-1:0]   sent_cnt_o,
  output logic               busy_o,
  output state_t             state_o
);
  localparam int                DW   = NUM_CH * ITEM_WIDTH;
  localparam int                AW   = $clog2(NUM_ITEMS);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_ITEMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITEMS - 1);

  state_t           r_state, w_state_nxt;
  logic             r_live;
  logic [CNT_W-1:0] r_fill_cnt, r_sent_cnt;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_all_loaded;
  logic             r_m_valid;
  logic [DW-1:0]    r_m_data;
  logic             r_xmit_en;

  logic             w_wr_ready, w_wr_acc, w_busy, w_start, w_batch_end;
  logic             w_accept, w_load_first, w_load_next, w_load;
  logic [CNT_W-1:0] w_last_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [DW-1:0]    w_rd_data;

  assign w_last_idx   = r_fill_cnt - CNT_W'(1);
  assign w_wr_acc     = wr.valid && w_wr_ready;
  assign w_accept     = r_m_valid && m.ready;
  // Entry 0 is loaded on start and, when looping, in the same edge as the
  // final acceptance so the next pass follows without a bubble.
  assign w_load_first = w_start || (w_batch_end && loop_i);
  assign w_load_next  = (r_state == SEND) && !w_batch_end && !r_all_loaded &&
                        (!r_m_valid || m.ready);
  assign w_load       = w_load_first || w_load_next;
  assign w_rd_idx     = w_load_first ? '0 : r_rd_ptr;

  tlm_feeder_buf #(.DEPTH(NUM_ITEMS), .AW(AW), .DW(DW)) u_buf (
    .i_clk   (clk_i),
    .i_we    (w_wr_acc),
    .i_waddr (r_fill_cnt[AW-1:0]),
    .i_wdata (wr.data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_wr_acc) w_state_nxt = FILL;
      FILL:  if ((w_wr_acc && (r_fill_cnt == LAST)) || flush_i) w_state_nxt = READY;
      READY: if (start_i) w_state_nxt = SEND;
      SEND:  if (w_batch_end && !loop_i) w_state_nxt = READY;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_ready  = 1'b0;
    w_busy      = 1'b0;
    w_start     = 1'b0;
    w_batch_end = 1'b0;
    unique case (r_state)
      IDLE, FILL: w_wr_ready = r_live && (r_fill_cnt < FULL);
      READY:      w_start    = start_i;
      SEND: begin
        w_busy      = 1'b1;
        w_batch_end = w_accept && (r_sent_cnt == w_last_idx);
      end
      default: ;
    endcase
  end

  // r_live keeps wr_ready low while reset is held.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_live       <= 1'b0;
      r_fill_cnt   <= '0;
      r_sent_cnt   <= '0;
      r_rd_ptr     <= '0;
      r_all_loaded <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_xmit_en    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wr_acc) r_fill_cnt <= r_fill_cnt + CNT_W'(1);

      if (w_load) begin
        r_m_data     <= w_rd_data;
        r_m_valid    <= 1'b1;
        r_all_loaded <= (CNT_W'(w_rd_idx) == w_last_idx);
        r_rd_ptr     <= (CNT_W'(w_rd_idx) == w_last_idx) ? '0 : w_rd_idx + AW'(1);
      end else if (w_batch_end) begin
        r_m_valid    <= 1'b0;
        r_all_loaded <= 1'b0;
      end

      if (w_batch_end)   r_sent_cnt <= '0;
      else if (w_accept) r_sent_cnt <= r_sent_cnt + CNT_W'(1);

      if (w_batch_end) r_xmit_en <= ~r_xmit_en;
    end
  end

  assign wr.ready     = w_wr_ready;
  assign m.valid      = r_m_valid;
  assign m.data       = r_m_data;
  assign batch_done_o = w_batch_end;
  assign xmit_en_o    = r_xmit_en;
  assign fill_cnt_o   = r_fill_cnt;
  assign sent_cnt_o   = r_sent_cnt;
  assign busy_o       = w_busy;
  assign state_o      = r_state;
endmodule

// File: tb/tb_tlm_stream_feeder.sv
// Directed bench for tlm_stream_feeder (4 entries x 2 operands x 8 bits):
// fill, stream, backpressure, loop, async reset, single-entry and flush batches.
module tb_tlm_stream_feeder;
  import tlm_feeder_pkg::*;

  localparam int N  = 4;
  localparam int CH = 2;
  localparam int IW = 8;
  localparam int DW = CH * IW;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic          flush, start, loop_en;
  logic          batch_done, xmit_en, busy;
  logic [CW-1:0] fill_cnt, sent_cnt;
  state_t        state;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] batch_a [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

  tlm_stream_feeder_if #(.DW(DW)) wr_if ();
  tlm_stream_feeder_if #(.DW(DW)) m_if ();

  tlm_stream_feeder #(.NUM_ITEMS(N), .NUM_CH(CH), .ITEM_WIDTH(IW)) dut (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .wr           (wr_if),
    .m            (m_if),
    .flush_i      (flush),
    .start_i      (start),
    .loop_i       (loop_en),
    .batch_done_o (batch_done),
    .xmit_en_o    (xmit_en),
    .fill_cnt_o   (fill_cnt),
    .sent_cnt_o   (sent_cnt),
    .busy_o       (busy),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [7:0] a, input logic [7:0] b, input logic fl);
    int n;
    n = 0;
    wr_if.valid = 1'b1;
    wr_if.data  = {b, a};
    flush       = fl;
    while (!wr_if.ready && n < 20) begin
      tick();
      n++;
    end
    check("wr_accept_in_time", 32'(n < 20), 32'd1);
    tick();
    wr_if.valid = 1'b0;
    flush       = 1'b0;
  endtask

  // Scoreboard: every beat accepted downstream must match the queue head.
  always @(negedge clk) begin
    if (rst_n && m_if.valid && m_if.ready) begin
      check("mon_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("mon_data", 32'(m_if.data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int   toggles;
    logic px;
    wr_if.valid = 1'b0;
    wr_if.data  = '0;
    m_if.ready  = 1'b0;
    flush       = 1'b0;
    start       = 1'b0;
    loop_en     = 1'b0;
    rst_n       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid",    32'(m_if.valid), 32'd0);
    check("rst_m_data",     32'(m_if.data),  32'd0);
    check("rst_wr_ready",   32'(wr_if.ready), 32'd0);
    check("rst_fill_cnt",   32'(fill_cnt),   32'd0);
    check("rst_sent_cnt",   32'(sent_cnt),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_xmit_en",    32'(xmit_en),    32'd0);
    check("rst_batch_done", 32'(batch_done), 32'd0);
    check("rst_state",      32'(state),      32'(IDLE));
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("idle_wr_ready", 32'(wr_if.ready), 32'd1);

    write_entry(8'h01, 8'h02, 1'b0);
    write_entry(8'h03, 8'h04, 1'b0);
    write_entry(8'h05, 8'h06, 1'b0);
    write_entry(8'h07, 8'h08, 1'b0);
    check("full_fill_cnt", 32'(fill_cnt),    32'd4);
    check("full_state",    32'(state),       32'(READY));
    check("full_wr_ready", 32'(wr_if.ready), 32'd0);

    wr_if.valid = 1'b1;
    wr_if.data  = 16'hEEEE;
    tick();
    wr_if.valid = 1'b0;
    check("overflow_fill_cnt", 32'(fill_cnt),    32'd4);
    check("overflow_wr_ready", 32'(wr_if.ready), 32'd0);

    for (int i = 0; i < 4; i++) exp_q.push_back(batch_a[i]);
    m_if.ready = 1'b1;
    start      = 1'b1;
    check("start_no_early_valid", 32'(m_if.valid), 32'd0);
    tick();
    start = 1'b0;
    check("send_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 32'(m_if.valid), 32'd1);
      check("stream_data",  32'(m_if.data),  32'(batch_a[i]));
      check("stream_done",  32'(batch_done), 32'(i == 3));
      check("stream_sent",  32'(sent_cnt),   32'(i));
      if (i == 0) check("stream_op1", operand_slice(MAX_DW'(m_if.data), 1, IW), 32'h02);
      tick();
    end
    check("end_valid",    32'(m_if.valid), 32'd0);
    check("end_xmit_en",  32'(xmit_en),    32'd1);
    check("end_state",    32'(state),      32'(READY));
    check("end_sent_cnt", 32'(sent_cnt),   32'd0);
    check("end_fill_cnt", 32'(fill_cnt),   32'd4);

    for (int i = 0; i < 4; i++) exp_q.push_back(batch_a[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_first", 32'(m_if.data), 32'h0201);
    tick();
    m_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data",  32'(m_if.data),  32'h0403);
      check("bp_hold_valid", 32'(m_if.valid), 32'd1);
      check("bp_hold_sent",  32'(sent_cnt),   32'd1);
      tick();
    end
    m_if.ready = 1'b1;
    check("bp_release_data", 32'(m_if.data), 32'h0403);
    tick();
    check("bp_next_data", 32'(m_if.data), 32'h0605);
    check("bp_next_sent", 32'(sent_cnt),  32'd2);
    tick();
    check("bp_last_data", 32'(m_if.data), 32'h0807);
    check("bp_last_done", 32'(batch_done), 32'd1);
    tick();
    check("bp_xmit_en", 32'(xmit_en),    32'd0);
    check("bp_valid",   32'(m_if.valid), 32'd0);

    for (int i = 0; i < 12; i++) exp_q.push_back(batch_a[i % 4]);
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    toggles = 0;
    px      = xmit_en;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) loop_en = 1'b0;
      check("loop_valid", 32'(m_if.valid), 32'd1);
      check("loop_data",  32'(m_if.data),  32'(batch_a[i % 4]));
      check("loop_done",  32'(batch_done), 32'((i % 4) == 3));
      tick();
      if (xmit_en != px) toggles++;
      px = xmit_en;
    end
    check("loop_toggles",    32'(toggles),       32'd3);
    check("loop_stop_valid", 32'(m_if.valid),    32'd0);
    check("loop_stop_state", 32'(state),         32'(READY));
    check("loop_q_empty",    32'(exp_q.size()),  32'd0);

    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",    32'(m_if.valid),   32'd0);
    check("midrst_data",     32'(m_if.data),    32'd0);
    check("midrst_busy",     32'(busy),         32'd0);
    check("midrst_fill_cnt", 32'(fill_cnt),     32'd0);
    check("midrst_sent_cnt", 32'(sent_cnt),     32'd0);
    check("midrst_state",    32'(state),        32'(IDLE));
    check("midrst_q_empty",  32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    write_entry(8'h09, 8'h09, 1'b0);
    check("one_fill_state", 32'(state), 32'(FILL));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("one_ready_state", 32'(state),    32'(READY));
    check("one_fill_cnt",    32'(fill_cnt), 32'd1);
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0909);
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) loop_en = 1'b0;
      check("one_data",  32'(m_if.data),  32'h0909);
      check("one_valid", 32'(m_if.valid), 32'd1);
      check("one_done",  32'(batch_done), 32'd1);
      tick();
    end
    check("one_stop_valid", 32'(m_if.valid),   32'd0);
    check("one_q_empty",    32'(exp_q.size()), 32'd0);

    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush_ignored", 32'(state),    32'(IDLE));
    check("idle_flush_fill",    32'(fill_cnt), 32'd0);
    write_entry(8'h11, 8'h22, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fill_start_state", 32'(state),      32'(FILL));
    check("fill_start_valid", 32'(m_if.valid), 32'd0);
    write_entry(8'h33, 8'h44, 1'b1);
    check("flush_state",    32'(state),       32'(READY));
    check("flush_fill_cnt", 32'(fill_cnt),    32'd2);
    check("flush_wr_ready", 32'(wr_if.ready), 32'd0);
    exp_q.push_back(16'h2211);
    exp_q.push_back(16'h4433);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_data0", 32'(m_if.data),  32'h2211);
    check("flush_done0", 32'(batch_done), 32'd0);
    tick();
    check("flush_data1", 32'(m_if.data),  32'h4433);
    check("flush_done1", 32'(batch_done), 32'd1);
    tick();
    check("flush_end_valid", 32'(m_if.valid), 32'd0);
    check("flush_xmit_en",   32'(xmit_en),    32'd1);
    check("final_q_empty",   32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlm_stream_feeder.md
Name: tlm_stream_feeder

Overview:
Parametrised successor to the payload-array stimulus wrapper. A batch buffer of NUM_ITEMS entries is filled through a valid/ready write port; each entry is NUM_CH operands of ITEM_WIDTH bits. On command, the block streams the batch to a downstream BFM over a proper valid/ready master port. Done is signalled by a one-cycle pulse and by the legacy xmit_en toggle. The block sits between the testbench/TLM layer and the DUT BFM.

Parameters:
NUM_ITEMS, 100, batch depth in entries (>=2)
NUM_CH, 2, operands per entry
ITEM_WIDTH, 8, bits per operand
CNT_W, $clog2(NUM_ITEMS+1), counter width (derived, localparam)

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous active-low reset
wr_valid_i  input  1  write entry valid
wr_ready_o  output  1  buffer accepts entry
wr_data_i  input  NUM_CH*ITEM_WIDTH  entry; operand k at bits [k*ITEM_WIDTH +: ITEM_WIDTH]
flush_i  input  1  close a partial batch (fill_cnt >= 1)
start_i  input  1  begin streaming, sampled in READY
loop_i  input  1  repeat batch until cleared, sampled at each batch end
m_valid_o  output  1  master data valid
m_ready_i  input  1  downstream ready
m_data_o  output  NUM_CH*ITEM_WIDTH  current entry, same packing
batch_done_o  output  1  one-cycle pulse when last entry is accepted
xmit_en_o  output  1  toggles on every batch_done_o
fill_cnt_o  output  CNT_W  entries held
sent_cnt_o  output  CNT_W  entries accepted in current pass
busy_o  output  1  high in SEND

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; fill_cnt, rd_ptr, sent_cnt = 0; buffer contents don't-care.
- States: IDLE -> FILL on first accepted write. FILL -> READY when fill_cnt reaches NUM_ITEMS, or on flush_i with fill_cnt>=1. READY -> SEND on start_i. SEND -> READY at batch end with loop_i=0. SEND -> SEND (rd_ptr=0) at batch end with loop_i=1.
- Write: wr_ready_o = 1 in IDLE/FILL while fill_cnt<NUM_ITEMS, else 0. A write is accepted on wr_valid_i && wr_ready_o. It stores to entry fill_cnt, then fill_cnt++.
- Write that makes fill_cnt=NUM_ITEMS: next state READY.
- flush_i in IDLE (empty): ignored.
- flush_i together with an accepted write: the write is included, then READY.
- Streaming: m_data_o/m_valid_o come from an output register. Load when !m_valid_o || m_ready_i.
- First m_valid_o rises 1 cycle after start_i is sampled. Zero-bubble throughput: 1 entry/cycle with m_ready_i held high.
- While m_valid_o && !m_ready_i, m_data_o and m_valid_o are held stable (AXI-stream rule).
- Acceptance = m_valid_o && m_ready_i; sent_cnt++ on each acceptance.
- Acceptance of entry fill_cnt-1: batch_done_o=1 for that cycle; xmit_en_o toggles; sent_cnt returns to 0.
- loop_i=1 at batch end: entry 0 presented with no bubble.
- loop_i=0 at batch end: m_valid_o drops next cycle; state READY with buffer retained; start_i replays the batch.
- Clearing the buffer: start_i is ignored while in IDLE/FILL. A new fill is possible only after reset.
- start_i in SEND: ignored. flush_i outside FILL: ignored.
- Batch of 1 entry: done on first acceptance; loop re-presents the same entry every cycle.
- Reset asserted mid-SEND: m_valid_o drops immediately (async); buffer is lost.

Decomposition:
- Package tlm_feeder_pkg: state enum (IDLE, FILL, READY, SEND) and an operand-slice helper function.
- One sub-module: tlm_feeder_buf, a NUM_ITEMS x (NUM_CH*ITEM_WIDTH) register array with a synchronous write and a combinational read port.
- FSM, counters and output register live in tlm_stream_feeder.

Test Plan:
- NUM_ITEMS=4, NUM_CH=2: write {A,B}=(1,2),(3,4),(5,6),(7,8); start_i; m_ready_i=1 -> m_data_o 0x0201,0x0403,0x0605,0x0807 on 4 consecutive cycles. batch_done_o pulses with 0x0807; xmit_en_o goes 0->1.
- Backpressure: m_ready_i low for 3 cycles while 0x0403 is valid -> m_data_o holds 0x0403 and m_valid_o stays 1. sent_cnt_o stays 1 until acceptance.
- Flush: write 2 entries, flush_i -> READY with fill_cnt_o=2, wr_ready_o=0. start_i -> 2 transfers, then batch_done_o.
- Loop: loop_i=1, 3 full passes of a 4-entry batch -> 12 consecutive acceptances with no bubble; xmit_en_o toggles 3 times; drop loop_i -> stream stops after the current pass.
- Full buffer: write 5th entry with wr_valid_i=1 at fill_cnt=4 -> wr_ready_o=0 and the entry is not stored.
- Reset mid-SEND after 2 acceptances -> all outputs 0 immediately. A refill of (9,9) streams only 0x0909.
